// File: rtl/box_motion_ctrl.sv
// Per-frame position/colour controller for the two overlay boxes.
// Updates are sequenced in vertical blanking through one shared step/clamp datapath.
module box_motion_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BOX_W     = 64,
  parameter int BOX_H     = 64,
  parameter int STEP_SLOW = 1,
  parameter int STEP_FAST = 4,
  parameter int BOX1_X0   = 64,
  parameter int BOX1_Y0   = 64,
  parameter int BOX2_X0   = 448,
  parameter int BOX2_Y0   = 320
) (
  input  logic        rfr_clk,
  input  logic        reset_n,
  input  logic [11:0] pixel_cnt,
  input  logic [11:0] line_cnt,
  input  logic        move_box1,
  input  logic        move_box2,
  input  logic        dColor_box1,
  input  logic        dColor_box2,
  input  logic [4:0]  move_dir,
  input  logic        speed,
  output logic [11:0] box1_x,
  output logic [11:0] box1_y,
  output logic [11:0] box2_x,
  output logic [11:0] box2_y,
  output logic [2:0]  box1_color,
  output logic [2:0]  box2_color,
  output logic        frame_tick,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, UPD1 = 2'd1, UPD2 = 2'd2, DONE = 2'd3} state_t;

  localparam logic [12:0] X_MAX = 13'(H_ACTIVE - BOX_W);
  localparam logic [12:0] Y_MAX = 13'(V_ACTIVE - BOX_H);

  state_t state;
  logic   dcol1_q, dcol2_q;
  logic   pend1, pend2;
  logic   edge1, edge2;
  logic   boundary;

  assign edge1     = dColor_box1 & ~dcol1_q;
  assign edge2     = dColor_box2 & ~dcol2_q;
  assign boundary  = (pixel_cnt == 12'd0) && (line_cnt == 12'(V_ACTIVE));
  assign dbg_state = state;

  // Shared step/clamp unit: operand select follows the FSM state, so box2 is only
  // ever computed in UPD2 and box1 in every other state (result used in UPD1 only).
  logic        sel2, mv, go_up, go_dn, go_lf, go_rt;
  logic [12:0] cx, cy, step, nx, ny;

  always_comb begin
    sel2  = (state == UPD2);
    cx    = sel2 ? {1'b0, box2_x} : {1'b0, box1_x};
    cy    = sel2 ? {1'b0, box2_y} : {1'b0, box1_y};
    step  = speed ? 13'(STEP_FAST) : 13'(STEP_SLOW);
    mv    = (sel2 ? move_box2 : move_box1) & ~move_dir[4];
    go_up = mv & move_dir[0] & ~move_dir[1];
    go_dn = mv & move_dir[1] & ~move_dir[0];
    go_lf = mv & move_dir[2] & ~move_dir[3];
    go_rt = mv & move_dir[3] & ~move_dir[2];
    nx    = cx;
    ny    = cy;
    if (go_lf)      nx = (cx < step) ? 13'd0 : cx - step;
    else if (go_rt) nx = (cx + step > X_MAX) ? X_MAX : cx + step;
    if (go_up)      ny = (cy < step) ? 13'd0 : cy - step;
    else if (go_dn) ny = (cy + step > Y_MAX) ? Y_MAX : cy + step;
  end

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      box1_x     <= 12'(BOX1_X0);
      box1_y     <= 12'(BOX1_Y0);
      box2_x     <= 12'(BOX2_X0);
      box2_y     <= 12'(BOX2_Y0);
      box1_color <= 3'd0;
      box2_color <= 3'd1;
      frame_tick <= 1'b0;
      dcol1_q    <= 1'b0;
      dcol2_q    <= 1'b0;
      pend1      <= 1'b0;
      pend2      <= 1'b0;
    end else begin
      dcol1_q    <= dColor_box1;
      dcol2_q    <= dColor_box2;
      frame_tick <= 1'b0;
      if (edge1) pend1 <= 1'b1;
      if (edge2) pend2 <= 1'b1;
      case (state)
        IDLE: if (boundary) state <= UPD1;
        UPD1: begin
          box1_x <= nx[11:0];
          box1_y <= ny[11:0];
          // An edge landing on the apply cycle also counts now and stays pending.
          if (pend1 || edge1) begin
            box1_color <= box1_color + 3'd1;
            pend1      <= edge1;
          end
          state <= UPD2;
        end
        UPD2: begin
          box2_x <= nx[11:0];
          box2_y <= ny[11:0];
          if (pend2 || edge2) begin
            box2_color <= box2_color + 3'd1;
            pend2      <= edge2;
          end
          frame_tick <= 1'b1;
          state      <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Directed bench for box_motion_ctrl: latency, motion, clamping, colour requests, reset.
// Inputs change and outputs are sampled on the falling edge of rfr_clk.
module tb_box_motion_ctrl;

  logic        rfr_clk = 1'b0;
  logic        reset_n;
  logic [11:0] pixel_cnt, line_cnt;
  logic        move_box1, move_box2, dColor_box1, dColor_box2, speed;
  logic [4:0]  move_dir;
  logic [11:0] box1_x, box1_y, box2_x, box2_y;
  logic [2:0]  box1_color, box2_color;
  logic        frame_tick;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 rfr_clk = ~rfr_clk;

  box_motion_ctrl dut (
    .rfr_clk(rfr_clk), .reset_n(reset_n), .pixel_cnt(pixel_cnt), .line_cnt(line_cnt),
    .move_box1(move_box1), .move_box2(move_box2), .dColor_box1(dColor_box1),
    .dColor_box2(dColor_box2), .move_dir(move_dir), .speed(speed),
    .box1_x(box1_x), .box1_y(box1_y), .box2_x(box2_x), .box2_y(box2_y),
    .box1_color(box1_color), .box2_color(box2_color), .frame_tick(frame_tick),
    .dbg_state(dbg_state)
  );

  // One boundary cycle followed by enough cycles for the sequence to return to IDLE.
  task automatic frame();
    @(negedge rfr_clk); pixel_cnt = 12'd0; line_cnt = 12'd480;
    @(negedge rfr_clk); pixel_cnt = 12'd1;
    repeat (4) @(negedge rfr_clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pixel_cnt = 12'd100; line_cnt = 12'd100;
    move_box1 = 0; move_box2 = 0; dColor_box1 = 0; dColor_box2 = 0;
    move_dir = 5'd0; speed = 0;
    repeat (3) @(negedge rfr_clk);
    reset_n = 1'b1;
    @(negedge rfr_clk);
    n_checks += 7;
    if (box1_x !== 12'd64)  begin n_fail++; $display("FAIL reset box1_x got %0d exp 64", box1_x); end
    if (box1_y !== 12'd64)  begin n_fail++; $display("FAIL reset box1_y got %0d exp 64", box1_y); end
    if (box2_x !== 12'd448) begin n_fail++; $display("FAIL reset box2_x got %0d exp 448", box2_x); end
    if (box2_y !== 12'd320) begin n_fail++; $display("FAIL reset box2_y got %0d exp 320", box2_y); end
    if (box1_color !== 3'd0 || box2_color !== 3'd1) begin
      n_fail++; $display("FAIL reset colors got %0d/%0d exp 0/1", box1_color, box2_color);
    end
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset frame_tick got %b exp 0", frame_tick); end
    if (dbg_state !== 2'd0)  begin n_fail++; $display("FAIL reset state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_idle_frames();
    logic [3:0] exp_tick;
    logic [3:0] got_tick;
    exp_tick = 4'b0100;  // visible in cycles 1..4 after the boundary cycle, high in cycle 3
    for (int f = 0; f < 2; f++) begin
      @(negedge rfr_clk); pixel_cnt = 12'd0; line_cnt = 12'd480;
      for (int c = 0; c < 4; c++) begin
        @(negedge rfr_clk); pixel_cnt = 12'd1;
        got_tick[c] = frame_tick;
      end
      repeat (2) @(negedge rfr_clk);
      n_checks += 2;
      if (got_tick !== exp_tick) begin
        n_fail++; $display("FAIL idle_tick frame %0d got %b exp %b", f, got_tick, exp_tick);
      end
      if (box1_x !== 12'd64 || box1_y !== 12'd64 || box2_x !== 12'd448 || box2_y !== 12'd320 ||
          box1_color !== 3'd0 || box2_color !== 3'd1) begin
        n_fail++; $display("FAIL idle_hold frame %0d got (%0d,%0d)/(%0d,%0d) c%0d/%0d", f,
                           box1_x, box1_y, box2_x, box2_y, box1_color, box2_color);
      end
    end
  endtask

  task automatic test_move_right();
    logic [11:0] exp_x;
    move_box1 = 1; move_dir = 5'b01000; speed = 1;
    exp_x = 12'd64;
    for (int f = 0; f < 3; f++) begin
      @(negedge rfr_clk); pixel_cnt = 12'd0; line_cnt = 12'd480;
      @(negedge rfr_clk); pixel_cnt = 12'd1;
      n_checks++;
      if (box1_x !== exp_x) begin n_fail++; $display("FAIL move_c1 got %0d exp %0d", box1_x, exp_x); end
      exp_x = exp_x + 12'd4;
      @(negedge rfr_clk);
      n_checks++;
      if (box1_x !== exp_x) begin n_fail++; $display("FAIL move_c2 got %0d exp %0d", box1_x, exp_x); end
      repeat (3) @(negedge rfr_clk);
      n_checks++;
      if (box2_x !== 12'd448 || box2_y !== 12'd320 || box1_y !== 12'd64) begin
        n_fail++; $display("FAIL move_others got b1y %0d b2 (%0d,%0d) exp 64 (448,320)", box1_y, box2_x, box2_y);
      end
    end
  endtask

  task automatic test_false_boundary();
    logic [11:0] pcs [4];
    logic [11:0] lcs [4];
    logic        seen_tick;
    pcs = '{12'd0, 12'd1, 12'hFFF, 12'd0};
    lcs = '{12'd481, 12'd480, 12'hFFF, 12'd479};
    seen_tick = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge rfr_clk); pixel_cnt = pcs[i]; line_cnt = lcs[i];
      repeat (4) begin @(negedge rfr_clk); seen_tick |= frame_tick; end
    end
    pixel_cnt = 12'd1; line_cnt = 12'd100;
    repeat (2) begin @(negedge rfr_clk); seen_tick |= frame_tick; end
    n_checks += 2;
    if (seen_tick !== 1'b0) begin n_fail++; $display("FAIL false_bnd tick got 1 exp 0"); end
    if (box1_x !== 12'd76) begin n_fail++; $display("FAIL false_bnd box1_x got %0d exp 76", box1_x); end
  endtask

  task automatic test_clamp_x();
    move_box1 = 1; move_dir = 5'b01000; speed = 1;
    repeat (124) frame();
    n_checks++;
    if (box1_x !== 12'd572) begin n_fail++; $display("FAIL clamp_r572 got %0d exp 572", box1_x); end
    speed = 0; repeat (2) frame();
    n_checks++;
    if (box1_x !== 12'd574) begin n_fail++; $display("FAIL clamp_r574 got %0d exp 574", box1_x); end
    speed = 1; frame();
    n_checks++;
    if (box1_x !== 12'd576) begin n_fail++; $display("FAIL clamp_r576 got %0d exp 576", box1_x); end
    frame();
    n_checks++;
    if (box1_x !== 12'd576) begin n_fail++; $display("FAIL clamp_rhold got %0d exp 576", box1_x); end
    move_dir = 5'b00100;
    repeat (143) frame();
    n_checks++;
    if (box1_x !== 12'd4) begin n_fail++; $display("FAIL clamp_l4 got %0d exp 4", box1_x); end
    speed = 0; repeat (2) frame();
    n_checks++;
    if (box1_x !== 12'd2) begin n_fail++; $display("FAIL clamp_l2 got %0d exp 2", box1_x); end
    speed = 1; frame();
    n_checks++;
    if (box1_x !== 12'd0) begin n_fail++; $display("FAIL clamp_l0 got %0d exp 0", box1_x); end
    frame();
    n_checks++;
    if (box1_x !== 12'd0 || box1_y !== 12'd64) begin
      n_fail++; $display("FAIL clamp_lhold got (%0d,%0d) exp (0,64)", box1_x, box1_y);
    end
  endtask

  task automatic test_diagonal_pause();
    move_box1 = 1; move_box2 = 0; move_dir = 5'b01000; speed = 0;
    repeat (10) frame();
    move_box2 = 1; move_dir = 5'b00111;
    frame();
    n_checks++;
    if (box1_x !== 12'd9 || box1_y !== 12'd64 || box2_x !== 12'd447 || box2_y !== 12'd320) begin
      n_fail++; $display("FAIL updown_left got (%0d,%0d)/(%0d,%0d) exp (9,64)/(447,320)",
                         box1_x, box1_y, box2_x, box2_y);
    end
    move_dir = 5'b10111;
    repeat (2) frame();
    n_checks++;
    if (box1_x !== 12'd9 || box1_y !== 12'd64 || box2_x !== 12'd447 || box2_y !== 12'd320) begin
      n_fail++; $display("FAIL pause got (%0d,%0d)/(%0d,%0d) exp (9,64)/(447,320)",
                         box1_x, box1_y, box2_x, box2_y);
    end
    move_box1 = 1; move_box2 = 1; move_dir = 5'b01001; speed = 1;
    frame();
    n_checks++;
    if (box1_x !== 12'd13 || box1_y !== 12'd60 || box2_x !== 12'd451 || box2_y !== 12'd316) begin
      n_fail++; $display("FAIL diag_ur got (%0d,%0d)/(%0d,%0d) exp (13,60)/(451,316)",
                         box1_x, box1_y, box2_x, box2_y);
    end
  endtask

  task automatic test_clamp_down();
    move_box1 = 0; move_box2 = 1; move_dir = 5'b00010; speed = 1;
    repeat (25) frame();
    n_checks++;
    if (box2_y !== 12'd416) begin n_fail++; $display("FAIL clamp_d416 got %0d exp 416", box2_y); end
    frame();
    n_checks++;
    if (box2_y !== 12'd416 || box2_x !== 12'd451 || box1_y !== 12'd60) begin
      n_fail++; $display("FAIL clamp_dhold got b2 (%0d,%0d) b1y %0d exp (451,416) 60", box2_x, box2_y, box1_y);
    end
  endtask

  task automatic test_color();
    move_box1 = 0; move_box2 = 0; move_dir = 5'd0;
    repeat (3) begin
      @(negedge rfr_clk); dColor_box2 = 1;
      @(negedge rfr_clk); dColor_box2 = 0;
    end
    frame();
    n_checks++;
    if (box2_color !== 3'd2) begin n_fail++; $display("FAIL color_collapse got %0d exp 2", box2_color); end
    frame();
    n_checks++;
    if (box2_color !== 3'd2) begin n_fail++; $display("FAIL color_noreq got %0d exp 2", box2_color); end
    @(negedge rfr_clk); pixel_cnt = 12'd0; line_cnt = 12'd480;
    @(negedge rfr_clk); pixel_cnt = 12'd1;
    @(negedge rfr_clk); dColor_box2 = 1;  // edge lands on the UPD2 cycle
    @(negedge rfr_clk); dColor_box2 = 0;
    n_checks++;
    if (box2_color !== 3'd3) begin n_fail++; $display("FAIL color_coincide got %0d exp 3", box2_color); end
    repeat (3) @(negedge rfr_clk);
    frame();
    n_checks++;
    if (box2_color !== 3'd4) begin n_fail++; $display("FAIL color_carry got %0d exp 4", box2_color); end
    frame();
    n_checks++;
    if (box2_color !== 3'd4) begin n_fail++; $display("FAIL color_settle got %0d exp 4", box2_color); end
    @(negedge rfr_clk); dColor_box1 = 1;
    @(negedge rfr_clk); dColor_box1 = 0;
    frame();
    n_checks++;
    if (box1_color !== 3'd1 || box2_color !== 3'd4) begin
      n_fail++; $display("FAIL color_box1 got %0d/%0d exp 1/4", box1_color, box2_color);
    end
  endtask

  task automatic test_reset_mid();
    move_box1 = 1; move_box2 = 1; move_dir = 5'b01000; speed = 0;
    @(negedge rfr_clk); pixel_cnt = 12'd0; line_cnt = 12'd480;
    @(negedge rfr_clk); pixel_cnt = 12'd1;
    n_checks++;
    if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL rstmid_state got %0d exp 1", dbg_state); end
    reset_n = 1'b0;
    #1;
    n_checks += 2;
    if (box1_x !== 12'd64 || box1_y !== 12'd64 || box2_x !== 12'd448 || box2_y !== 12'd320 ||
        box1_color !== 3'd0 || box2_color !== 3'd1 || frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_out got (%0d,%0d)/(%0d,%0d) c%0d/%0d t%b", box1_x, box1_y,
                         box2_x, box2_y, box1_color, box2_color, frame_tick);
    end
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rstmid_idle got %0d exp 0", dbg_state); end
    @(negedge rfr_clk); reset_n = 1'b1;
    repeat (4) @(negedge rfr_clk);
    n_checks++;
    if (box1_x !== 12'd64 || box2_x !== 12'd448 || frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_hold got %0d/%0d t%b exp 64/448 t0", box1_x, box2_x, frame_tick);
    end
    frame();
    n_checks++;
    if (box1_x !== 12'd65 || box2_x !== 12'd449 || box1_y !== 12'd64 || box2_y !== 12'd320) begin
      n_fail++; $display("FAIL rstmid_next got (%0d,%0d)/(%0d,%0d) exp (65,64)/(449,320)",
                         box1_x, box1_y, box2_x, box2_y);
    end
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_move_right();
    test_false_boundary();
    test_clamp_x();
    test_diagonal_pause();
    test_clamp_down();
    test_color();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
